// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: drain FSM encoding, entry layout
// and pointer sizing helpers.
package store_buffer_pkg;

  // Default geometry; the top module may override these via parameters.
  localparam int unsigned SB_DEPTH = 4;
  localparam int unsigned SB_AW    = 32;
  localparam int unsigned SB_DW    = 32;

  // Entry = word address (byte offset dropped) + data word.
  function automatic int unsigned sb_entry_w(input int unsigned aw, input int unsigned dw);
    return aw - 2 + dw;
  endfunction

  // Pointer width for a power-of-2 FIFO depth.
  function automatic int unsigned sb_ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  localparam int unsigned SB_ENTRY_W = sb_entry_w(SB_AW, SB_DW);
  localparam int unsigned SB_PTR_W   = sb_ptr_w(SB_DEPTH);

  typedef enum logic {
    SB_IDLE  = 1'b0,
    SB_WRITE = 1'b1
  } sb_state_e;

  typedef struct packed {
    logic [SB_AW-3:0] tag;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match priority selector for store-to-load forwarding.
// Scans entries from the slot just below the tail (youngest) back towards
// the oldest and reports the first valid entry whose word address matches.
module sb_fwd_match #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TW    = 30
) (
  input  logic [DEPTH-1:0]                 i_valid,
  input  logic [DEPTH-1:0][TW-1:0]         i_tag,
  input  logic [$clog2(DEPTH)-1:0]         i_tail,
  input  logic [TW-1:0]                    i_addr,
  output logic                             o_hit,
  output logic [$clog2(DEPTH)-1:0]         o_idx
);

  localparam int unsigned PW = $clog2(DEPTH);

  // w_ord[k] is the slot k+1 places behind the tail, i.e. youngest first.
  // Pointer arithmetic wraps modulo DEPTH because DEPTH is a power of 2.
  logic [DEPTH-1:0][PW-1:0] w_ord;

  for (genvar k = 0; k < DEPTH; k++) begin : g_ord
    assign w_ord[k] = i_tail - PW'(k + 1);
  end

  // First valid tag match in youngest-to-oldest order wins.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!o_hit && i_valid[w_ord[k]] && (i_tag[w_ord[k]] == i_addr)) begin
        o_hit = 1'b1;
        o_idx = w_ord[k];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between the MEM stage and data RAM.
// Stores retire into a small circular FIFO which drains through a req/ack
// write port; loads read RAM directly and are forwarded from the youngest
// buffered store to the same word.
// Optional statistics outputs are enabled with the macro STORE_BUF_STATS_EN.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH,
  parameter int unsigned AW    = SB_AW,
  parameter int unsigned DW    = SB_DW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       memwriteM,
  input  logic                       memreadM,
  input  logic [AW-1:0]              aluoutM,
  input  logic [DW-1:0]              WriteDataM,
  output logic [DW-1:0]              readdata,
  output logic                       stall_req,
  output logic [AW-1:0]              ram_raddr,
  input  logic [DW-1:0]              ram_rdata,
  output logic                       ram_wreq,
  output logic [AW-1:0]              ram_waddr,
  output logic [DW-1:0]              ram_wdata,
  input  logic                       ram_wack,
`ifdef STORE_BUF_STATS_EN
  output logic [31:0]                fwd_cnt,
  output logic [31:0]                stall_cnt,
  output logic [$clog2(DEPTH):0]     hiwater,
`endif
  output logic                       empty
);

  localparam int unsigned PW = sb_ptr_w(DEPTH);
  localparam int unsigned TW = AW - 2;
  localparam int unsigned EW = sb_entry_w(AW, DW);

  // FIFO storage: each entry is {word address, data}.
  logic [DEPTH-1:0][EW-1:0] r_entry;
  logic [DEPTH-1:0]         r_valid;
  logic [PW-1:0]            r_head;
  logic [PW-1:0]            r_tail;
  logic [PW:0]              r_count;

  // Drain FSM and its registered write-port outputs.
  sb_state_e                r_state;
  logic                     r_wreq;
  logic [AW-1:0]            r_waddr;
  logic [DW-1:0]            r_wdata;

  logic                     w_pop;
  logic                     w_push;
  logic                     w_full;
  logic [PW:0]              w_cnt_nxt;
  logic [EW-1:0]            w_new_entry;
  logic [PW-1:0]            w_head_nxt;
  logic [EW-1:0]            w_next_entry;
  logic [DEPTH-1:0][TW-1:0] w_tag;
  logic                     w_hit;
  logic [PW-1:0]            w_hit_idx;
  logic                     w_fwd;

  assign w_full      = (r_count == (PW+1)'(DEPTH));
  assign w_pop       = (r_state == SB_WRITE) && ram_wack;
  // A full buffer still accepts a store in the cycle its head is popped.
  assign w_push      = memwriteM && (!w_full || w_pop);
  assign w_cnt_nxt   = r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
  assign w_new_entry = {aluoutM[AW-1:2], WriteDataM};
  assign w_head_nxt  = r_head + PW'(1);

  // With one entry left, the only possible successor is the store arriving
  // now, which has not reached the storage array yet.
  assign w_next_entry = (r_count == (PW+1)'(1)) ? w_new_entry : r_entry[w_head_nxt];

  for (genvar i = 0; i < DEPTH; i++) begin : g_tag
    assign w_tag[i] = r_entry[i][EW-1:DW];
  end

  // FIFO storage, pointers and occupancy; push after pop so a full-buffer
  // push into the slot being freed leaves it valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_entry <= '0;
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= w_head_nxt;
      end
      if (w_push) begin
        r_entry[r_tail] <= w_new_entry;
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PW'(1);
      end
      r_count <= w_cnt_nxt;
    end
  end

  // Drain FSM: presents the head entry and holds it until acknowledged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SB_IDLE;
      r_wreq  <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        SB_IDLE: begin
          if (r_count != '0) begin
            r_state <= SB_WRITE;
            r_wreq  <= 1'b1;
            r_waddr <= {r_entry[r_head][EW-1:DW], 2'b00};
            r_wdata <= r_entry[r_head][DW-1:0];
          end
        end
        SB_WRITE: begin
          if (ram_wack) begin
            if (w_cnt_nxt != '0) begin
              r_waddr <= {w_next_entry[EW-1:DW], 2'b00};
              r_wdata <= w_next_entry[DW-1:0];
            end else begin
              r_state <= SB_IDLE;
              r_wreq  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= SB_IDLE;
          r_wreq  <= 1'b0;
        end
      endcase
    end
  end

  sb_fwd_match #(
    .DEPTH (DEPTH),
    .TW    (TW)
  ) u_fwd_match (
    .i_valid (r_valid),
    .i_tag   (w_tag),
    .i_tail  (r_tail),
    .i_addr  (aluoutM[AW-1:2]),
    .o_hit   (w_hit),
    .o_idx   (w_hit_idx)
  );

  // An entry popped this cycle is still valid here; its RAM write only lands
  // at the next edge, so forwarding keeps the load coherent.
  assign w_fwd     = memreadM && w_hit;
  assign readdata  = w_fwd ? r_entry[w_hit_idx][DW-1:0] : ram_rdata;
  assign ram_raddr = aluoutM;
  assign stall_req = memwriteM && w_full && !w_pop;
  assign ram_wreq  = r_wreq;
  assign ram_waddr = r_waddr;
  assign ram_wdata = r_wdata;
  assign empty     = (r_count == '0) && (r_state == SB_IDLE);

`ifdef STORE_BUF_STATS_EN
  logic [31:0] r_fwd_cnt;
  logic [31:0] r_stall_cnt;
  logic [PW:0] r_hiwater;

  // Saturating event counters and occupancy high-water mark.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fwd_cnt   <= '0;
      r_stall_cnt <= '0;
      r_hiwater   <= '0;
    end else begin
      if (w_fwd && (r_fwd_cnt != '1)) begin
        r_fwd_cnt <= r_fwd_cnt + 32'd1;
      end
      if (stall_req && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (r_count > r_hiwater) begin
        r_hiwater <= r_count;
      end
    end
  end

  assign fwd_cnt   = r_fwd_cnt;
  assign stall_cnt = r_stall_cnt;
  assign hiwater   = r_hiwater;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH=4, AW=DW=32).
module tb_store_buffer;

  logic        clk;
  logic        rst;
  logic        memwriteM;
  logic        memreadM;
  logic [31:0] aluoutM;
  logic [31:0] WriteDataM;
  logic [31:0] readdata;
  logic        stall_req;
  logic [31:0] ram_raddr;
  logic [31:0] ram_rdata;
  logic        ram_wreq;
  logic [31:0] ram_waddr;
  logic [31:0] ram_wdata;
  logic        ram_wack;
  logic        empty;
`ifdef STORE_BUF_STATS_EN
  logic [31:0] fwd_cnt;
  logic [31:0] stall_cnt;
  logic [2:0]  hiwater;
`endif

  int n_err;
  int n_chk;

  // RAM read-data source: a fixed value, or the RAM model in the wrap test.
  logic        use_model;
  logic [31:0] rdata_drv;
  logic [31:0] ram_mem [16];
  logic [31:0] arch    [16];

  always_comb begin
    ram_rdata = use_model ? ram_mem[aluoutM[5:2]] : rdata_drv;
  end

  store_buffer #(
    .DEPTH (4),
    .AW    (32),
    .DW    (32)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .memwriteM  (memwriteM),
    .memreadM   (memreadM),
    .aluoutM    (aluoutM),
    .WriteDataM (WriteDataM),
    .readdata   (readdata),
    .stall_req  (stall_req),
    .ram_raddr  (ram_raddr),
    .ram_rdata  (ram_rdata),
    .ram_wreq   (ram_wreq),
    .ram_waddr  (ram_waddr),
    .ram_wdata  (ram_wdata),
    .ram_wack   (ram_wack),
`ifdef STORE_BUF_STATS_EN
    .fwd_cnt    (fwd_cnt),
    .stall_cnt  (stall_cnt),
    .hiwater    (hiwater),
`endif
    .empty      (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put_store(input logic [31:0] a, input logic [31:0] d);
    memwriteM  = 1'b1;
    memreadM   = 1'b0;
    aluoutM    = a;
    WriteDataM = d;
  endtask

  task automatic put_load(input logic [31:0] a);
    memwriteM = 1'b0;
    memreadM  = 1'b1;
    aluoutM   = a;
  endtask

  task automatic idle_bus();
    memwriteM = 1'b0;
    memreadM  = 1'b0;
  endtask

  logic [31:0] st_a [7];
  logic [15:0] ack_pat;
  logic [63:0] exp_q [$];
  int          si;
  int          nwr;

  initial begin
    n_err      = 0;
    n_chk      = 0;
    rst        = 1'b1;
    memwriteM  = 1'b0;
    memreadM   = 1'b0;
    aluoutM    = '0;
    WriteDataM = '0;
    ram_wack   = 1'b0;
    use_model  = 1'b0;
    rdata_drv  = 32'h0;
    for (int i = 0; i < 16; i++) begin
      ram_mem[i] = '0;
      arch[i]    = '0;
    end
    st_a    = '{32'h80, 32'h84, 32'h80, 32'h88, 32'h8C, 32'h84, 32'h80};
    ack_pat = 16'b0110_0011_1001_0100;

    // Reset state
    #2;
    check_eq("rst_wreq", ram_wreq, 0);
    check_eq("rst_stall", stall_req, 0);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_waddr", ram_waddr, 0);
    check_eq("rst_wdata", ram_wdata, 0);
    step();
    rst = 1'b0;
    step();

    // Single store with ack tied high
    ram_wack = 1'b1;
    put_store(32'h10, 32'hDEADBEEF);
    step();
    idle_bus();
    #1;
    check_eq("s1_wreq_lo", ram_wreq, 0);
    check_eq("s1_not_empty", empty, 0);
    step();
    check_eq("s1_wreq", ram_wreq, 1);
    check_eq("s1_waddr", ram_waddr, 32'h10);
    check_eq("s1_wdata", ram_wdata, 32'hDEADBEEF);
    step();
    check_eq("s1_wreq_done", ram_wreq, 0);
    check_eq("s1_empty", empty, 1);

    // Fill to DEPTH, then a fifth store stalls until an ack frees a slot
    ram_wack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      put_store(32'(4 * i), 32'hA0 + 32'(i));
      #1;
      check_eq("fill_stall", stall_req, 0);
      step();
    end
    put_store(32'h20, 32'hA4);
    #1;
    check_eq("full_stall0", stall_req, 1);
    step();
    check_eq("full_stall1", stall_req, 1);
    check_eq("full_head", ram_waddr, 32'h0);
    ram_wack = 1'b1;
    #1;
    check_eq("full_ack_stall", stall_req, 0);
    step();
    idle_bus();
    ram_wack = 1'b0;
    #1;
    check_eq("full_next_addr", ram_waddr, 32'h4);
    check_eq("full_next_data", ram_wdata, 32'hA1);
    put_store(32'h24, 32'hBB);
    #1;
    check_eq("full_count4", stall_req, 1);
    idle_bus();
    ram_wack = 1'b1;
    #1;
    check_eq("drain_a1", ram_waddr, 32'h4);
    step();
    check_eq("drain_a2", ram_waddr, 32'h8);
    step();
    check_eq("drain_a3", ram_waddr, 32'hC);
    step();
    check_eq("drain_a4", ram_waddr, 32'h20);
    check_eq("drain_d4", ram_wdata, 32'hA4);
    step();
    check_eq("drain_wreq", ram_wreq, 0);
    check_eq("drain_empty", empty, 1);

    // Youngest-match forwarding
    ram_wack  = 1'b0;
    rdata_drv = 32'h9999;
    put_store(32'h40, 32'h1111);
    step();
    put_store(32'h40, 32'h2222);
    step();
    put_load(32'h40);
    #1;
    check_eq("fwd_youngest", readdata, 32'h2222);
    put_load(32'h44);
    #1;
    check_eq("fwd_miss", readdata, 32'h9999);
    idle_bus();
    aluoutM = 32'h40;
    #1;
    check_eq("fwd_noread", readdata, 32'h9999);

    // Forward from an entry popped in the same cycle
    ram_wack = 1'b1;
    step();
    check_eq("pop_next_data", ram_wdata, 32'h2222);
    put_load(32'h40);
    #1;
    check_eq("fwd_popping", readdata, 32'h2222);
    step();
    ram_wack = 1'b0;
    #1;
    check_eq("fwd_after_pop", readdata, 32'h9999);
    check_eq("fwd_after_empty", empty, 1);
    idle_bus();

    // Wrap: 7 stores through DEPTH=4 against RAM and architectural models
    use_model = 1'b1;
    si        = 0;
    nwr       = 0;
    for (int c = 0; c < 200; c++) begin
      if (si == 7 && exp_q.size() == 0 && empty) break;
      ram_wack = ack_pat[c % 16];
      if ((c % 2 == 0) && (si < 7)) begin
        put_store(st_a[si], 32'h5000 + 32'(si));
      end else begin
        put_load(32'h80 + 32'(4 * (c % 4)));
      end
      #1;
      if (memreadM) begin
        check_eq("wrap_load", readdata, arch[aluoutM[5:2]]);
      end
      if (ram_wreq && ram_wack) begin
        nwr++;
        if (exp_q.size() != 0) begin
          check_eq("wrap_order", {ram_waddr, ram_wdata}, exp_q[0]);
          void'(exp_q.pop_front());
        end
        ram_mem[ram_waddr[5:2]] = ram_wdata;
      end
      if (memwriteM && !stall_req) begin
        arch[aluoutM[5:2]] = WriteDataM;
        exp_q.push_back({aluoutM, WriteDataM});
        si++;
      end
      step();
    end
    idle_bus();
    ram_wack = 1'b0;
    check_eq("wrap_stores", si, 7);
    check_eq("wrap_writes", nwr, 7);
    check_eq("wrap_empty", empty, 1);
    use_model = 1'b0;

    // Reset in the middle of a write with three entries queued
    put_store(32'h100, 32'h1);
    step();
    put_store(32'h104, 32'h2);
    step();
    put_store(32'h108, 32'h3);
    step();
    idle_bus();
    #1;
    check_eq("mid_wreq", ram_wreq, 1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_wreq", ram_wreq, 0);
    check_eq("mid_rst_empty", empty, 1);
    check_eq("mid_rst_stall", stall_req, 0);
    step();
    rst = 1'b0;
    step();
    ram_wack = 1'b1;
    put_store(32'h200, 32'h7777);
    step();
    idle_bus();
    #1;
    check_eq("fresh_idle", ram_wreq, 0);
    step();
    check_eq("fresh_wreq", ram_wreq, 1);
    check_eq("fresh_waddr", ram_waddr, 32'h200);
    check_eq("fresh_wdata", ram_wdata, 32'h7777);
    step();
    check_eq("fresh_empty", empty, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
